bht_predictor: RTL and testbench



---
 rtl/bp_pkg.sv | 46 ++++
 rtl/bp_sat_counter.sv | 41 ++++
 rtl/bht_predictor.sv | 86 ++++++++
 tb/tb_bht_predictor.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared definitions for the branch history table: counter reset value, taken threshold,
// saturating step and parameter legality checks. Counters up to 4 bits use cnt_word_t.
package bp_pkg;

  localparam int unsigned CNT_W_MIN = 32'd2;
  localparam int unsigned CNT_W_MAX = 32'd4;

  typedef logic [CNT_W_MAX-1:0] cnt_word_t;

  function automatic cnt_word_t rst_cnt(input int unsigned cnt_w);
    return cnt_word_t'((32'd1 << (cnt_w - 32'd1)) - 32'd1);
  endfunction

  function automatic cnt_word_t cnt_max(input int unsigned cnt_w);
    return cnt_word_t'((32'd1 << cnt_w) - 32'd1);
  endfunction

  function automatic logic cnt_taken(input cnt_word_t cnt, input int unsigned cnt_w);
    cnt_word_t sh;
    sh = cnt >> (cnt_w - 32'd1);
    return sh[0];
  endfunction

  // Saturates at both ends; never wraps.
  function automatic cnt_word_t sat_step(input cnt_word_t cnt, input int unsigned cnt_w,
                                         input logic dir);
    cnt_word_t res;
    if (dir) begin
      if (cnt == cnt_max(cnt_w)) res = cnt;
      else                       res = cnt + 4'd1;
    end else begin
      if (cnt == 4'd0) res = cnt;
      else             res = cnt - 4'd1;
    end
    return res;
  endfunction

  function automatic logic cnt_w_legal(input int unsigned cnt_w);
    return (cnt_w >= CNT_W_MIN) && (cnt_w <= CNT_W_MAX);
  endfunction

  function automatic logic ghr_w_legal(input int unsigned ghr_w, input int unsigned idx_w);
    return (ghr_w >= 32'd1) && (ghr_w <= idx_w);
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// One saturating prediction counter. clr_i (synchronous) beats en_i; rst_n is asynchronous.
module bp_sat_counter
  import bp_pkg::*;
#(
  parameter int unsigned CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             dir_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] count_o
);

  localparam logic [CNT_W-1:0] RST_CNT = CNT_W'(rst_cnt(CNT_W));

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  cnt_word_t        step_s;

  assign step_s = sat_step(cnt_word_t'(count_q), CNT_W, dir_i);

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = RST_CNT;
    end else if (en_i) begin
      count_d = CNT_W'(step_s);
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= RST_CNT;
    else        count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/bht_predictor.sv
// Branch history table: combinational lookup, registered update, read-before-write on
// same-index collisions. Define GSHARE_EN to XOR a non-speculative global history into the index.
module bht_predictor
  import bp_pkg::*;
#(
  parameter int unsigned PC_W  = 32,
  parameter int unsigned IDX_W = 6,
  parameter int unsigned CNT_W = 2,
  parameter int unsigned GHR_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             lookup_valid,
  input  logic [PC_W-1:0]  lookup_pc,
  output logic             predict_taken,
  output logic [IDX_W-1:0] predict_idx,
  input  logic             update_valid,
  input  logic [IDX_W-1:0] update_idx,
  input  logic             update_taken,
  input  logic             clear
);

  localparam int unsigned ENTRIES = 32'd1 << IDX_W;

  if (!cnt_w_legal(CNT_W)) begin : g_bad_cnt_w
    $error("bht_predictor: CNT_W must be in 2..4");
  end

  logic [CNT_W-1:0] cnt_s [ENTRIES];
  logic [IDX_W-1:0] pc_idx_s;
  logic             unused_pc_s;

  assign pc_idx_s    = lookup_pc[IDX_W+1:2];
  assign unused_pc_s = ^{lookup_pc[PC_W-1:IDX_W+2], lookup_pc[1:0]};

  for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
    bp_sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .en_i    (update_valid && (update_idx == IDX_W'(i))),
      .dir_i   (update_taken),
      .clr_i   (clear),
      .count_o (cnt_s[i])
    );
  end

`ifdef GSHARE_EN
  if (!ghr_w_legal(GHR_W, IDX_W)) begin : g_bad_ghr_w
    $error("bht_predictor: GHR_W must be in 1..IDX_W");
  end

  logic [GHR_W-1:0] ghr_q;
  logic [GHR_W-1:0] ghr_d;

  // History is fed only by resolved branches, so it never needs repair.
  always_comb begin
    ghr_d = ghr_q;
    if (clear) begin
      ghr_d = '0;
    end else if (update_valid) begin
      ghr_d = GHR_W'({ghr_q, update_taken});
    end else begin
      ghr_d = ghr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ghr_q <= '0;
    else        ghr_q <= ghr_d;
  end

  assign predict_idx = pc_idx_s ^ IDX_W'(ghr_q);
`else
  assign predict_idx = pc_idx_s;
`endif

  always_comb begin
    predict_taken = 1'b0;
    if (lookup_valid) begin
      predict_taken = cnt_taken(cnt_word_t'(cnt_s[predict_idx]), CNT_W);
    end else begin
      predict_taken = 1'b0;
    end
  end

endmodule

// File: tb/tb_bht_predictor.sv
// Self-checking bench for bht_predictor (default CNT_W=2, IDX_W=6): reference table model,
// expected results queued at drive time and compared after the combinational lookup settles.
module tb_bht_predictor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        lookup_valid = 1'b0;
  logic [31:0] lookup_pc = 32'h0;
  logic        predict_taken;
  logic [5:0]  predict_idx;
  logic        update_valid = 1'b0;
  logic [5:0]  update_idx = 6'd0;
  logic        update_taken = 1'b0;
  logic        clear = 1'b0;

  typedef struct {
    string      tag;
    logic       taken;
    logic [5:0] idx;
  } exp_t;

  exp_t       sb[$];
  logic [1:0] m_tab [64];
  logic [5:0] m_ghr;
  int         n_tests = 0;
  int         n_fail  = 0;

  always #5 clk = ~clk;

  bht_predictor #(.PC_W(32), .IDX_W(6), .CNT_W(2), .GHR_W(6)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .lookup_valid  (lookup_valid),
    .lookup_pc     (lookup_pc),
    .predict_taken (predict_taken),
    .predict_idx   (predict_idx),
    .update_valid  (update_valid),
    .update_idx    (update_idx),
    .update_taken  (update_taken),
    .clear         (clear)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_tab[i] = 2'b01;
    m_ghr = 6'd0;
  endtask

  function automatic logic [31:0] pc_for(input logic [5:0] idx);
    return {24'h0, idx ^ m_ghr, 2'b00};
  endfunction

  // One cycle: drive at negedge, queue expectation from the pre-update model, compare, clock.
  task automatic step(input string tag, input logic lv, input logic [31:0] pc,
                      input logic uv, input logic [5:0] uidx, input logic ut, input logic clr);
    exp_t e;
    exp_t g;
    logic [5:0] li;
    @(negedge clk);
    lookup_valid = lv;
    lookup_pc    = pc;
    update_valid = uv;
    update_idx   = uidx;
    update_taken = ut;
    clear        = clr;
    li = pc[7:2] ^ m_ghr;
    e.tag   = tag;
    e.idx   = li;
    e.taken = lv & m_tab[li][1];
    sb.push_back(e);
    #1;
    g = sb.pop_front();
    check_eq({g.tag, "_idx"}, 32'(predict_idx), 32'(g.idx));
    check_eq({g.tag, "_taken"}, 32'(predict_taken), 32'(g.taken));
    @(posedge clk);
    if (clr) begin
      model_reset();
    end else if (uv) begin
      if (ut && m_tab[uidx] != 2'b11) m_tab[uidx] = m_tab[uidx] + 2'd1;
      else if (!ut && m_tab[uidx] != 2'b00) m_tab[uidx] = m_tab[uidx] - 2'd1;
`ifdef GSHARE_EN
      m_ghr = {m_ghr[4:0], ut};
`endif
    end
  endtask

  task automatic upd(input string tag, input logic ut, input int n);
    for (int k = 0; k < n; k++) step(tag, 1'b0, 32'h0, 1'b1, 6'd5, ut, 1'b0);
  endtask

  task automatic look5(input string tag, input logic exp);
    logic [31:0] pc;
    pc = pc_for(6'd5);
    step(tag, 1'b1, pc, 1'b0, 6'd0, 1'b0, 1'b0);
    check_eq({tag, "_abs"}, 32'(m_tab[5][1]), 32'(exp));
  endtask

  initial begin
    model_reset();
    #12 rst_n = 1'b1;

    // Reset state: every index predicts not-taken, and the lookup is gated by lookup_valid.
    for (int i = 0; i < 64; i++) step("rst_all", 1'b1, {24'h0, 6'(i), 2'(i)}, 1'b0, 6'd0, 1'b0, 1'b0);
    step("lv0", 1'b0, 32'h14, 1'b0, 6'd0, 1'b0, 1'b0);

    // Taken saturation on idx 5; one step from reset already flips the prediction.
    upd("t1", 1'b1, 1);
    look5("after_t1", 1'b1);
    upd("t2", 1'b1, 1);
    look5("after_t2", 1'b1);
    upd("t_sat", 1'b1, 4);
    upd("n1", 1'b0, 1);
    look5("after_n1", 1'b1);
    upd("n2", 1'b0, 1);
    look5("after_n2", 1'b0);
    upd("n_sat", 1'b0, 4);
    upd("t_from0", 1'b1, 1);
    look5("from0", 1'b0);

    // Read-before-write collision at the counter value 01.
    step("rbw_same", 1'b1, pc_for(6'd5), 1'b1, 6'd5, 1'b1, 1'b0);
    look5("rbw_next", 1'b1);

    // Clear beats a simultaneous update; the dropped update must not land.
    upd("to11", 1'b1, 1);
    step("clr_upd", 1'b1, pc_for(6'd5), 1'b1, 6'd5, 1'b1, 1'b1);
    look5("after_clr", 1'b0);
    upd("clr_chk", 1'b1, 1);
    look5("clr_was01", 1'b1);

    // Asynchronous reset mid-operation is visible before the next clock edge.
    upd("pre_rst", 1'b1, 1);
    @(negedge clk);
    rst_n        = 1'b0;
    update_valid = 1'b0;
    clear        = 1'b0;
    lookup_valid = 1'b1;
    lookup_pc    = pc_for(6'd5);
    model_reset();
    #1;
    check_eq("async_rst_taken", 32'(predict_taken), 32'(1'b0));
    @(negedge clk);
    rst_n = 1'b1;
    look5("post_rst", 1'b0);

`ifdef GSHARE_EN
    step("g_t1", 1'b0, 32'h0, 1'b1, 6'd9, 1'b1, 1'b0);
    step("g_t2", 1'b0, 32'h0, 1'b1, 6'd9, 1'b1, 1'b0);
    step("g_n1", 1'b0, 32'h0, 1'b1, 6'd9, 1'b0, 1'b0);
    check_eq("ghr_model", 32'(m_ghr), 32'(6'b000110));
    step("g_look", 1'b1, 32'h14, 1'b0, 6'd0, 1'b0, 1'b0);
    @(negedge clk);
    lookup_pc = 32'h14;
    #1;
    check_eq("gshare_idx", 32'(predict_idx), 32'(6'd3));
`endif

    // Random mix of lookups, updates and occasional clears against the model.
    for (int r = 0; r < 400; r++) begin
      logic [31:0] rpc;
      rpc = $urandom;
      step("rand", 1'($urandom_range(0, 1)), rpc, 1'($urandom_range(0, 1)),
           6'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), ($urandom_range(0, 31) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
